crtc_reg_file: RTL and testbench

CRTC_REG_FILE -- requirements
Module: crtc_reg_file

---
 rtl/common_pkg.sv | 81 ++++++++
 rtl/wb_responder_fsm.sv | 47 ++++
 rtl/crtc_reg_file.sv | 139 +++++++++++++
 tb/tb_crtc_reg_file.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared CRTC register indices, reset values and write masks used by the PET CRTC blocks.
// The masks are applied only when CRTC_REG_MASK_EN is defined (see crtc_reg_file).
package common_pkg;

    localparam int CRTC_ADDR_WIDTH = 5;
    localparam int CRTC_REG_COUNT  = 14;
    localparam int CRTC_DATA_WIDTH = 8;

    localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R0_H_TOTAL       = 5'd0;
    localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R1_H_DISPLAYED   = 5'd1;
    localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R2_H_SYNC_POS    = 5'd2;
    localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R3_SYNC_WIDTH    = 5'd3;
    localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R4_V_TOTAL       = 5'd4;
    localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R5_V_ADJUST      = 5'd5;
    localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R6_V_DISPLAYED   = 5'd6;
    localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R7_V_SYNC_POS    = 5'd7;
    localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R9_MAX_SCAN_LINE = 5'd9;
    localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R12_START_HI     = 5'd12;
    localparam logic [CRTC_ADDR_WIDTH-1:0] CRTC_R13_START_LO     = 5'd13;

    localparam logic [7:0] CRTC_RESET_R0  = 8'd49;
    localparam logic [7:0] CRTC_RESET_R1  = 8'd40;
    localparam logic [7:0] CRTC_RESET_R2  = 8'd41;
    localparam logic [7:0] CRTC_RESET_R3  = 8'h0F;
    localparam logic [7:0] CRTC_RESET_R4  = 8'd39;
    localparam logic [7:0] CRTC_RESET_R5  = 8'd0;
    localparam logic [7:0] CRTC_RESET_R6  = 8'd25;
    localparam logic [7:0] CRTC_RESET_R7  = 8'd29;
    localparam logic [7:0] CRTC_RESET_R9  = 8'd7;
    localparam logic [7:0] CRTC_RESET_R12 = 8'h10;
    localparam logic [7:0] CRTC_RESET_R13 = 8'h00;

    typedef enum logic {
        WB_IDLE,
        WB_ACK
    } wb_resp_state_e;

    function automatic logic crtc_reg_implemented(input logic [CRTC_ADDR_WIDTH-1:0] idx);
        logic impl;
        case (idx)
            CRTC_R0_H_TOTAL, CRTC_R1_H_DISPLAYED, CRTC_R2_H_SYNC_POS,
            CRTC_R3_SYNC_WIDTH, CRTC_R4_V_TOTAL, CRTC_R5_V_ADJUST,
            CRTC_R6_V_DISPLAYED, CRTC_R7_V_SYNC_POS, CRTC_R9_MAX_SCAN_LINE,
            CRTC_R12_START_HI, CRTC_R13_START_LO: impl = 1'b1;
            default:                              impl = 1'b0;
        endcase
        return impl;
    endfunction

    function automatic logic [7:0] crtc_reset_value(input logic [CRTC_ADDR_WIDTH-1:0] idx);
        logic [7:0] value;
        case (idx)
            CRTC_R0_H_TOTAL:       value = CRTC_RESET_R0;
            CRTC_R1_H_DISPLAYED:   value = CRTC_RESET_R1;
            CRTC_R2_H_SYNC_POS:    value = CRTC_RESET_R2;
            CRTC_R3_SYNC_WIDTH:    value = CRTC_RESET_R3;
            CRTC_R4_V_TOTAL:       value = CRTC_RESET_R4;
            CRTC_R5_V_ADJUST:      value = CRTC_RESET_R5;
            CRTC_R6_V_DISPLAYED:   value = CRTC_RESET_R6;
            CRTC_R7_V_SYNC_POS:    value = CRTC_RESET_R7;
            CRTC_R9_MAX_SCAN_LINE: value = CRTC_RESET_R9;
            CRTC_R12_START_HI:     value = CRTC_RESET_R12;
            CRTC_R13_START_LO:     value = CRTC_RESET_R13;
            default:               value = 8'h00;
        endcase
        return value;
    endfunction

    // Bits that carry meaning in each register; the rest read back as zero when masking.
    function automatic logic [7:0] crtc_write_mask(input logic [CRTC_ADDR_WIDTH-1:0] idx);
        logic [7:0] mask;
        case (idx)
            CRTC_R4_V_TOTAL, CRTC_R6_V_DISPLAYED, CRTC_R7_V_SYNC_POS: mask = 8'h7F;
            CRTC_R5_V_ADJUST, CRTC_R9_MAX_SCAN_LINE:                  mask = 8'h1F;
            CRTC_R12_START_HI:                                        mask = 8'h3F;
            default:                                                  mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/wb_responder_fsm.sv
// Single-beat pipelined Wishbone responder handshake (IDLE/ACK), shared by register-style slaves.
// hold_i lets the owner stall new requests while it services a higher-priority writer.
module wb_responder_fsm
    import common_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic req_i,
    input  logic hold_i,
    output logic stall_o,
    output logic ack_o,
    output logic accept_o
);

    wb_resp_state_e state_q;
    logic           ack_q;

    // Reset masks ack/stall immediately so an in-flight beat is dropped without an ack.
    assign stall_o  = !reset_i && ((state_q == WB_ACK) || hold_i);
    assign accept_o = req_i && !reset_i && !stall_o;
    assign ack_o    = ack_q && !reset_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= WB_IDLE;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                WB_IDLE: begin
                    if (accept_o) begin
                        state_q <= WB_ACK;
                        ack_q   <= 1'b1;
                    end
                end
                WB_ACK: begin
                    state_q <= WB_IDLE;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= WB_IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/crtc_reg_file.sv
// PET 6845 CRTC register file, writable from the PET CPU (index/data) and from Wishbone.
// Define CRTC_REG_MASK_EN to clear undefined high bits on write so they read back as zero.
module crtc_reg_file
    import common_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH    = CRTC_DATA_WIDTH
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0]    wb_data_i,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    input  logic                     wb_we_i,
    input  logic                     wb_cycle_i,
    input  logic                     wb_strobe_i,
    input  logic                     wb_sel_i,
    output logic                     wb_stall_o,
    output logic                     wb_ack_o,
    input  logic                     cpu_wr_strobe_i,
    input  logic                     cpu_rs_i,
    input  logic [7:0]               cpu_data_i,
    output logic [7:0]               h_total_o,
    output logic [7:0]               h_displayed_o,
    output logic [7:0]               h_sync_pos_o,
    output logic [3:0]               h_sync_width_o,
    output logic [4:0]               v_sync_width_o,
    output logic [6:0]               v_total_o,
    output logic [6:0]               v_displayed_o,
    output logic [6:0]               v_sync_pos_o,
    output logic [4:0]               v_adjust_o,
    output logic [4:0]               max_scan_line_o,
    output logic [13:0]              start_addr_o,
    output logic                     reg_update_o
);

    localparam int SEL_W = $clog2(CRTC_REG_COUNT);

    logic [7:0]                 regs_q [CRTC_REG_COUNT];
    logic [7:0]                 regs_d [CRTC_REG_COUNT];
    logic [CRTC_ADDR_WIDTH-1:0] index_q, index_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       reg_update_q, reg_update_d;

    logic                       wb_req;
    logic                       wb_accept;
    logic [CRTC_ADDR_WIDTH-1:0] wb_idx;
    logic [CRTC_ADDR_WIDTH-1:0] wr_idx;
    logic [7:0]                 wr_data;
    logic [7:0]                 wr_value;
    logic                       wr_en;
    logic [7:0]                 rd_value;
    logic [3:0]                 r3_vsync;
    logic                       unused_addr_bits;

    assign wb_req           = wb_cycle_i && wb_strobe_i && wb_sel_i;
    assign wb_idx           = wb_addr_i[CRTC_ADDR_WIDTH-1:0];
    assign unused_addr_bits = ^wb_addr_i[WB_ADDR_WIDTH-1:CRTC_ADDR_WIDTH];

    wb_responder_fsm u_wb_fsm (
        .clk_i    (wb_clock_i),
        .reset_i  (wb_reset_i),
        .req_i    (wb_req),
        .hold_i   (cpu_wr_strobe_i),
        .stall_o  (wb_stall_o),
        .ack_o    (wb_ack_o),
        .accept_o (wb_accept)
    );

    // The CPU strobe stalls Wishbone, so at most one write source is active per cycle.
    always_comb begin
        index_d = index_q;
        wr_en   = 1'b0;
        wr_idx  = wb_idx;
        wr_data = wb_data_i[7:0];
        if (cpu_wr_strobe_i) begin
            if (cpu_rs_i) begin
                wr_en   = 1'b1;
                wr_idx  = index_q;
                wr_data = cpu_data_i;
            end else begin
                index_d = cpu_data_i[CRTC_ADDR_WIDTH-1:0];
            end
        end else if (wb_accept && wb_we_i) begin
            wr_en = 1'b1;
        end

`ifdef CRTC_REG_MASK_EN
        wr_value = wr_data & crtc_write_mask(wr_idx);
`else
        wr_value = wr_data;
`endif

        regs_d       = regs_q;
        reg_update_d = 1'b0;
        if (wr_en && crtc_reg_implemented(wr_idx)) begin
            regs_d[wr_idx[SEL_W-1:0]] = wr_value;
            reg_update_d              = 1'b1;
        end

        rd_value = crtc_reg_implemented(wb_idx) ? regs_q[wb_idx[SEL_W-1:0]] : 8'h00;
        rdata_d  = wb_accept ? DATA_WIDTH'(rd_value) : rdata_q;
    end

    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i) begin
            for (int i = 0; i < CRTC_REG_COUNT; i++) begin
                regs_q[i] <= crtc_reset_value(CRTC_ADDR_WIDTH'(i));
            end
            index_q      <= '0;
            rdata_q      <= '0;
            reg_update_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            index_q      <= index_d;
            rdata_q      <= rdata_d;
            reg_update_q <= reg_update_d;
        end
    end

    assign wb_data_o    = rdata_q;
    assign reg_update_o = reg_update_q;

    assign h_total_o       = regs_q[SEL_W'(CRTC_R0_H_TOTAL)];
    assign h_displayed_o   = regs_q[SEL_W'(CRTC_R1_H_DISPLAYED)];
    assign h_sync_pos_o    = regs_q[SEL_W'(CRTC_R2_H_SYNC_POS)];
    assign h_sync_width_o  = regs_q[SEL_W'(CRTC_R3_SYNC_WIDTH)][3:0];
    assign r3_vsync        = regs_q[SEL_W'(CRTC_R3_SYNC_WIDTH)][7:4];
    // A vertical sync width of zero means the full 16 lines.
    assign v_sync_width_o  = (r3_vsync == 4'd0) ? 5'd16 : {1'b0, r3_vsync};
    assign v_total_o       = regs_q[SEL_W'(CRTC_R4_V_TOTAL)][6:0];
    assign v_adjust_o      = regs_q[SEL_W'(CRTC_R5_V_ADJUST)][4:0];
    assign v_displayed_o   = regs_q[SEL_W'(CRTC_R6_V_DISPLAYED)][6:0];
    assign v_sync_pos_o    = regs_q[SEL_W'(CRTC_R7_V_SYNC_POS)][6:0];
    assign max_scan_line_o = regs_q[SEL_W'(CRTC_R9_MAX_SCAN_LINE)][4:0];
    assign start_addr_o    = {regs_q[SEL_W'(CRTC_R12_START_HI)][5:0],
                              regs_q[SEL_W'(CRTC_R13_START_LO)]};

endmodule

// File: tb/tb_crtc_reg_file.sv
// Directed self-checking bench for crtc_reg_file; expectations follow CRTC_REG_MASK_EN when defined.
`timescale 1ns/1ps
module tb_crtc_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] wb_addr;
    logic [7:0]  wb_din;
    logic [7:0]  wb_dout;
    logic        wb_we, wb_cyc, wb_stb, wb_sel;
    logic        wb_stall, wb_ack;
    logic        cpu_stb, cpu_rs;
    logic [7:0]  cpu_d;
    logic [7:0]  h_total, h_displayed, h_sync_pos;
    logic [3:0]  h_sync_width;
    logic [4:0]  v_sync_width;
    logic [6:0]  v_total, v_displayed, v_sync_pos;
    logic [4:0]  v_adjust, max_scan_line;
    logic [13:0] start_addr;
    logic        reg_update;

    int n_cmp = 0;
    int n_bad = 0;
    int upd_count = 0;

    always #7.8125 clk = ~clk;

    always @(posedge clk) if (reg_update === 1'b1) upd_count++;

    crtc_reg_file dut (
        .wb_clock_i(clk), .wb_reset_i(rst), .wb_addr_i(wb_addr), .wb_data_i(wb_din),
        .wb_data_o(wb_dout), .wb_we_i(wb_we), .wb_cycle_i(wb_cyc), .wb_strobe_i(wb_stb),
        .wb_sel_i(wb_sel), .wb_stall_o(wb_stall), .wb_ack_o(wb_ack),
        .cpu_wr_strobe_i(cpu_stb), .cpu_rs_i(cpu_rs), .cpu_data_i(cpu_d),
        .h_total_o(h_total), .h_displayed_o(h_displayed), .h_sync_pos_o(h_sync_pos),
        .h_sync_width_o(h_sync_width), .v_sync_width_o(v_sync_width), .v_total_o(v_total),
        .v_displayed_o(v_displayed), .v_sync_pos_o(v_sync_pos), .v_adjust_o(v_adjust),
        .max_scan_line_o(max_scan_line), .start_addr_o(start_addr), .reg_update_o(reg_update)
    );

    // Drives one Wishbone beat starting at a negedge; returns handshake observations.
    task automatic wb_xfer(input logic we, input logic [4:0] idx, input logic [7:0] wdata,
                           output int stalls, output logic ack_pre, output logic ack,
                           output logic [7:0] rdata, output logic ack_post, output logic timed_out);
        wb_addr = {11'd0, idx};
        wb_din  = wdata;
        wb_we   = we;
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
        wb_sel  = 1'b1;
        stalls  = 0;
        timed_out = 1'b0;
        #1;
        ack_pre = wb_ack;
        while (wb_stall === 1'b1 && stalls < 8) begin
            @(negedge clk);
            cpu_stb = 1'b0;
            stalls++;
            #1;
        end
        if (wb_stall !== 1'b0) timed_out = 1'b1;
        @(negedge clk);
        ack   = wb_ack;
        rdata = wb_dout;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_sel = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        ack_post = wb_ack;
    endtask

    task automatic cpu_write(input logic rs, input logic [7:0] d);
        cpu_stb = 1'b1;
        cpu_rs  = rs;
        cpu_d   = d;
        @(negedge clk);
        cpu_stb = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ack: got %0d expected 0", wb_ack); end
        n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_stall: got %0d expected 0", wb_stall); end
        n_cmp++; if (reg_update !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_reg_update: got %0d expected 0", reg_update); end
        n_cmp++; if (wb_dout !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_wb_data: got %0h expected 0", wb_dout); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (h_total !== 8'd49) begin n_bad++; $display("[TB] FAIL reset_h_total: got %0d expected 49", h_total); end
        n_cmp++; if (h_displayed !== 8'd40) begin n_bad++; $display("[TB] FAIL reset_h_displayed: got %0d expected 40", h_displayed); end
        n_cmp++; if (h_sync_pos !== 8'd41) begin n_bad++; $display("[TB] FAIL reset_h_sync_pos: got %0d expected 41", h_sync_pos); end
        n_cmp++; if (h_sync_width !== 4'd15) begin n_bad++; $display("[TB] FAIL reset_h_sync_width: got %0d expected 15", h_sync_width); end
        n_cmp++; if (v_sync_width !== 5'd16) begin n_bad++; $display("[TB] FAIL reset_v_sync_width: got %0d expected 16", v_sync_width); end
        n_cmp++; if (v_total !== 7'd39) begin n_bad++; $display("[TB] FAIL reset_v_total: got %0d expected 39", v_total); end
        n_cmp++; if (v_adjust !== 5'd0) begin n_bad++; $display("[TB] FAIL reset_v_adjust: got %0d expected 0", v_adjust); end
        n_cmp++; if (v_displayed !== 7'd25) begin n_bad++; $display("[TB] FAIL reset_v_displayed: got %0d expected 25", v_displayed); end
        n_cmp++; if (v_sync_pos !== 7'd29) begin n_bad++; $display("[TB] FAIL reset_v_sync_pos: got %0d expected 29", v_sync_pos); end
        n_cmp++; if (max_scan_line !== 5'd7) begin n_bad++; $display("[TB] FAIL reset_max_scan_line: got %0d expected 7", max_scan_line); end
        n_cmp++; if (start_addr !== 14'h1000) begin n_bad++; $display("[TB] FAIL reset_start_addr: got %0h expected 1000", start_addr); end
        n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL post_reset_stall: got %0d expected 0", wb_stall); end
    endtask

    task automatic test_wb_read();
        int st; logic ap, a, apo, to; logic [7:0] rd;
        wb_xfer(1'b0, 5'd1, 8'h00, st, ap, a, rd, apo, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("[TB] FAIL read_r1_timeout: got %0d expected 0", to); end
        n_cmp++; if (st != 0) begin n_bad++; $display("[TB] FAIL read_r1_stalls: got %0d expected 0", st); end
        n_cmp++; if (ap !== 1'b0) begin n_bad++; $display("[TB] FAIL read_r1_ack_early: got %0d expected 0", ap); end
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("[TB] FAIL read_r1_ack: got %0d expected 1", a); end
        n_cmp++; if (rd !== 8'd40) begin n_bad++; $display("[TB] FAIL read_r1_data: got %0d expected 40", rd); end
        n_cmp++; if (apo !== 1'b0) begin n_bad++; $display("[TB] FAIL read_r1_ack_width: got %0d expected 0", apo); end
    endtask

    task automatic test_cpu_write();
        int u0;
        u0 = upd_count;
        cpu_stb = 1'b1; cpu_rs = 1'b0; cpu_d = 8'h0C;
        #1;
        n_cmp++; if (wb_stall !== 1'b1) begin n_bad++; $display("[TB] FAIL cpu_stall: got %0d expected 1", wb_stall); end
        @(negedge clk);
        cpu_stb = 1'b0;
        cpu_write(1'b1, 8'h12);
        repeat (2) @(negedge clk);
        n_cmp++; if (start_addr[13:8] !== 6'h12) begin n_bad++; $display("[TB] FAIL cpu_start_hi: got %0h expected 12", start_addr[13:8]); end
        n_cmp++; if (start_addr !== 14'h1200) begin n_bad++; $display("[TB] FAIL cpu_start_addr: got %0h expected 1200", start_addr); end
        n_cmp++; if (upd_count - u0 != 1) begin n_bad++; $display("[TB] FAIL cpu_update_pulses: got %0d expected 1", upd_count - u0); end
        cpu_write(1'b1, 8'h05);
        repeat (2) @(negedge clk);
        n_cmp++; if (start_addr !== 14'h0500) begin n_bad++; $display("[TB] FAIL cpu_index_kept: got %0h expected 0500", start_addr); end
        n_cmp++; if (upd_count - u0 != 2) begin n_bad++; $display("[TB] FAIL cpu_update_total: got %0d expected 2", upd_count - u0); end
    endtask

    task automatic test_collision();
        int st; logic ap, a, apo, to; logic [7:0] rd;
        cpu_write(1'b0, 8'h00);
        cpu_stb = 1'b1; cpu_rs = 1'b1; cpu_d = 8'h33;
        wb_xfer(1'b1, 5'd0, 8'h5A, st, ap, a, rd, apo, to);
        n_cmp++; if (st != 1) begin n_bad++; $display("[TB] FAIL collide_stalls: got %0d expected 1", st); end
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("[TB] FAIL collide_ack: got %0d expected 1", a); end
        n_cmp++; if (rd !== 8'h33) begin n_bad++; $display("[TB] FAIL collide_old_data: got %0h expected 33", rd); end
        n_cmp++; if (h_total !== 8'h5A) begin n_bad++; $display("[TB] FAIL collide_h_total: got %0h expected 5a", h_total); end
        wb_xfer(1'b0, 5'd0, 8'h00, st, ap, a, rd, apo, to);
        n_cmp++; if (rd !== 8'h5A) begin n_bad++; $display("[TB] FAIL collide_readback: got %0h expected 5a", rd); end
    endtask

    task automatic test_mask();
        int st; logic ap, a, apo, to; logic [7:0] rd;
        logic [7:0] exp_r4, exp_r12;
`ifdef CRTC_REG_MASK_EN
        exp_r4 = 8'h7F; exp_r12 = 8'h3F;
`else
        exp_r4 = 8'hFF; exp_r12 = 8'hFF;
`endif
        wb_xfer(1'b1, 5'd4, 8'hFF, st, ap, a, rd, apo, to);
        n_cmp++; if (v_total !== 7'd127) begin n_bad++; $display("[TB] FAIL mask_v_total: got %0d expected 127", v_total); end
        wb_xfer(1'b0, 5'd4, 8'h00, st, ap, a, rd, apo, to);
        n_cmp++; if (rd !== exp_r4) begin n_bad++; $display("[TB] FAIL mask_r4_readback: got %0h expected %0h", rd, exp_r4); end
        wb_xfer(1'b1, 5'd12, 8'hFF, st, ap, a, rd, apo, to);
        n_cmp++; if (start_addr[13:8] !== 6'h3F) begin n_bad++; $display("[TB] FAIL mask_start_hi: got %0h expected 3f", start_addr[13:8]); end
        wb_xfer(1'b0, 5'd12, 8'h00, st, ap, a, rd, apo, to);
        n_cmp++; if (rd !== exp_r12) begin n_bad++; $display("[TB] FAIL mask_r12_readback: got %0h expected %0h", rd, exp_r12); end
    endtask

    task automatic test_sync_width();
        int st; logic ap, a, apo, to; logic [7:0] rd;
        wb_xfer(1'b1, 5'd3, 8'h05, st, ap, a, rd, apo, to);
        n_cmp++; if (v_sync_width !== 5'd16) begin n_bad++; $display("[TB] FAIL sync_v_width_zero: got %0d expected 16", v_sync_width); end
        n_cmp++; if (h_sync_width !== 4'd5) begin n_bad++; $display("[TB] FAIL sync_h_width: got %0d expected 5", h_sync_width); end
        wb_xfer(1'b1, 5'd3, 8'h35, st, ap, a, rd, apo, to);
        n_cmp++; if (v_sync_width !== 5'd3) begin n_bad++; $display("[TB] FAIL sync_v_width: got %0d expected 3", v_sync_width); end
    endtask

    task automatic test_unimplemented();
        int st, u0; logic ap, a, apo, to; logic [7:0] rd;
        u0 = upd_count;
        wb_xfer(1'b1, 5'd20, 8'hAA, st, ap, a, rd, apo, to);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("[TB] FAIL unimpl_ack: got %0d expected 1", a); end
        wb_xfer(1'b0, 5'd20, 8'h00, st, ap, a, rd, apo, to);
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("[TB] FAIL unimpl_r20_read: got %0h expected 0", rd); end
        cpu_write(1'b0, 8'hE8);
        cpu_write(1'b1, 8'h77);
        wb_xfer(1'b0, 5'd8, 8'h00, st, ap, a, rd, apo, to);
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("[TB] FAIL unimpl_r8_read: got %0h expected 0", rd); end
        repeat (2) @(negedge clk);
        n_cmp++; if (upd_count != u0) begin n_bad++; $display("[TB] FAIL unimpl_update: got %0d expected %0d", upd_count, u0); end
    endtask

    task automatic test_reset_in_ack();
        wb_addr = 16'd1; wb_din = 8'h11; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_sel = 1'b1;
        #1;
        n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL rstack_pre_stall: got %0d expected 0", wb_stall); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_sel = 1'b0; wb_we = 1'b0;
        #1;
        n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL rstack_ack_now: got %0d expected 0", wb_ack); end
        @(posedge clk);
        #1;
        n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL rstack_ack_held: got %0d expected 0", wb_ack); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL rstack_ack_after: got %0d expected 0", wb_ack); end
        n_cmp++; if (h_displayed !== 8'd40) begin n_bad++; $display("[TB] FAIL rstack_r1_reset: got %0d expected 40", h_displayed); end
        n_cmp++; if (wb_dout !== 8'h00) begin n_bad++; $display("[TB] FAIL rstack_data: got %0h expected 0", wb_dout); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        wb_addr = '0; wb_din = '0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_sel = 1'b0;
        cpu_stb = 1'b0; cpu_rs = 1'b0; cpu_d = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_wb_read();
        test_cpu_write();
        test_collision();
        test_mask();
        test_sync_width();
        test_unimplemented();
        test_reset_in_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
